// File: rtl/mux_rr_2x1.sv
// mux_rr_2x1: merges two 8-bit lanes through per-lane FIFOs into one registered
//   output stream, using round-robin arbitration between the two lanes.
// Latency: 2 edges from a push into an empty, idle block to valid_out=1. There
//   is no bypass path. Throughput is one word per cycle.
// Backpressure: data_out/valid_out hold while valid_out=1 and ready_out=0.
//   A lane drops its input while its FIFO is full.
// Optional feature: define MUX_RR_OVF_FLAG_EN to make err_ovf a sticky flag
//   that records dropped words. Without it, err_ovf is tied to 0.
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-high reset
//   in0/in1            lane data words
//   valid0/valid1      lane data qualifiers
//   full0/full1        lane FIFO holds DEPTH words (combinational)
//   ready_out          downstream accepts data_out this cycle
//   data_out           merged data word (registered)
//   valid_out          data_out qualifier (registered)
//   err_ovf            sticky overflow flag
module mux_rr_2x1 #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic       valid0,
  input  logic       valid1,
  output logic       full0,
  output logic       full1,
  input  logic       ready_out,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       err_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem0 [DEPTH];
  logic [7:0]    mem1 [DEPTH];
  logic [AW-1:0] wp0, rp0, wp1, rp1;
  logic [CW-1:0] cnt0, cnt1;
  logic          last_grant;   // 1 = lane 1 was granted last

  logic empty0, empty1;
  logic push0, push1;
  logic load, pop_any, pop0, pop1, sel;
  logic [7:0] pop_word;

  assign full0  = (cnt0 == CW'(DEPTH));
  assign full1  = (cnt1 == CW'(DEPTH));
  assign empty0 = (cnt0 == '0);
  assign empty1 = (cnt1 == '0);

  // Pushes are gated by the pre-edge full flag.
  // A pop on the same edge does not make room for the incoming word.
  assign push0 = valid0 & ~full0;
  assign push1 = valid1 & ~full1;

  assign load = ~valid_out | ready_out;

  // Round-robin select. On a tie, grant the lane that was not granted last.
  always_comb begin
    sel = 1'b0;
    if (!empty0 && !empty1) sel = ~last_grant;
    else if (!empty0)       sel = 1'b0;
    else                    sel = 1'b1;
  end

  assign pop_any  = load & (~empty0 | ~empty1);
  assign pop0     = pop_any & ~sel;
  assign pop1     = pop_any & sel;
  assign pop_word = sel ? mem1[rp1] : mem0[rp0];

  // The storage array needs no reset, because the pointers define
  // which entries are live.
  always_ff @(posedge clk) begin
    if (push0) mem0[wp0] <= in0;
    if (push1) mem1[wp1] <= in1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp0 <= '0;
      rp0 <= '0;
      cnt0 <= '0;
      wp1 <= '0;
      rp1 <= '0;
      cnt1 <= '0;
    end else begin
      if (push0) wp0 <= wp0 + AW'(1);
      if (pop0)  rp0 <= rp0 + AW'(1);
      cnt0 <= cnt0 + CW'(push0) - CW'(pop0);
      if (push1) wp1 <= wp1 + AW'(1);
      if (pop1)  rp1 <= rp1 + AW'(1);
      cnt1 <= cnt1 + CW'(push1) - CW'(pop1);
    end
  end

  // Output register. Reset leaves last_grant=1, so lane 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= 8'h00;
      valid_out  <= 1'b0;
      last_grant <= 1'b1;
    end else if (load) begin
      if (pop_any) begin
        data_out   <= pop_word;
        valid_out  <= 1'b1;
        last_grant <= sel;
      end else begin
        valid_out  <= 1'b0;
      end
    end
  end

`ifdef MUX_RR_OVF_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf <= 1'b0;
    end else if ((valid0 & full0) | (valid1 & full1)) begin
      err_ovf <= 1'b1;
    end
  end
`else
  assign err_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mux_rr_2x1.sv
// Bench for mux_rr_2x1.
// A queue-based reference model predicts each word the block loads into
// its output register. A negedge monitor checks every DUT handshake and
// per-cycle flag against that prediction.
module tb_mux_rr_2x1;

  localparam int DEPTH = 4;
`ifdef MUX_RR_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in0, in1;
  logic       valid0, valid1, ready_out;
  logic       full0, full1, valid_out, err_ovf;
  logic [7:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;

  // Reference model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] sb[$];
  logic       m_vo, m_last, m_err;
  logic [7:0] m_do;

  mux_rr_2x1 #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst),
    .in0(in0), .in1(in1), .valid0(valid0), .valid1(valid1),
    .full0(full0), .full1(full1), .ready_out(ready_out),
    .data_out(data_out), .valid_out(valid_out), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per-lane queues of capacity DEPTH and a one-word output stage.
  // A pop uses pre-edge state, and so does the full test for incoming words.
  always @(posedge clk or posedge rst) begin : model
    int lane;
    logic [7:0] w;
    bit f0, f1;
    if (rst) begin
      q0.delete();
      q1.delete();
      sb.delete();
      m_vo   <= 1'b0;
      m_do   <= 8'h00;
      m_last <= 1'b1;
      m_err  <= 1'b0;
    end else begin
      f0 = (q0.size() == DEPTH);
      f1 = (q1.size() == DEPTH);
      if (!m_vo || ready_out) begin
        if (q0.size() != 0 || q1.size() != 0) begin
          if (q0.size() != 0 && q1.size() != 0) lane = m_last ? 0 : 1;
          else lane = (q0.size() != 0) ? 0 : 1;
          if (lane == 0) w = q0.pop_front();
          else w = q1.pop_front();
          sb.push_back(w);
          m_do   <= w;
          m_vo   <= 1'b1;
          m_last <= (lane == 1);
        end else begin
          m_vo <= 1'b0;
        end
      end
      if (valid0) begin
        if (!f0) q0.push_back(in0);
        else if (OVF_EN) m_err <= 1'b1;
      end
      if (valid1) begin
        if (!f1) q1.push_back(in1);
        else if (OVF_EN) m_err <= 1'b1;
      end
    end
  end

  // Monitor: checks the per-cycle flags, then consumes the scoreboard
  // on each output handshake.
  always @(negedge clk) begin : monitor
    logic [7:0] exp;
    if (!rst) begin
      check("valid_out", {31'b0, valid_out}, {31'b0, m_vo});
      check("full0", {31'b0, full0}, {31'b0, (q0.size() == DEPTH)});
      check("full1", {31'b0, full1}, {31'b0, (q1.size() == DEPTH)});
      check("err_ovf", {31'b0, err_ovf}, {31'b0, m_err});
      if (valid_out && ready_out) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: got word %0h, expected none (t=%0t)", data_out, $time);
        end else begin
          exp = sb.pop_front();
          check("data_out", {24'b0, data_out}, {24'b0, exp});
          n_out++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v0, input logic [7:0] d0, input bit v1,
                       input logic [7:0] d1, input bit r);
    valid0 = v0;
    in0 = d0;
    valid1 = v1;
    in1 = d1;
    ready_out = r;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    valid0 = 1'b0;
    valid1 = 1'b0;
    ready_out = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    tick();
  endtask

  int base;

  initial begin
    rst = 1'b1;
    in0 = 8'h00;
    in1 = 8'h00;
    valid0 = 1'b0;
    valid1 = 1'b0;
    ready_out = 1'b0;
    #12;
    check("rst_valid_out", {31'b0, valid_out}, 32'd0);
    check("rst_data_out", {24'b0, data_out}, 32'd0);
    check("rst_full0", {31'b0, full0}, 32'd0);
    check("rst_full1", {31'b0, full1}, 32'd0);
    check("rst_err_ovf", {31'b0, err_ovf}, 32'd0);
    #10 rst = 1'b0;
    tick();

    // Single-lane stream 00..07: first valid_out 2 edges after the first push.
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
      if (i == 0) check("lat_edge1", {31'b0, valid_out}, 32'd0);
      if (i == 1) check("lat_edge2", {31'b0, valid_out}, 32'd1);
    end
    idle(6);
    check("stream_count", n_out - base, 32'd8);

    // Both lanes after reset: the outputs interleave A0,B0,...
    do_reset();
    base = n_out;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i), 1'b1);
    idle(10);
    check("rr_count", n_out - base, 32'd8);

    // Overflow with the output stalled: 10..14 are stored and 15 is dropped.
    base = n_out;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 8'h00, 1'b0);
    check("ovf_full0", {31'b0, full0}, 32'd1);
    check("ovf_err", {31'b0, err_ovf}, {31'b0, OVF_EN});
    idle(8);
    check("ovf_count", n_out - base, 32'd5);

    // ready_out toggling during a stream.
    base = n_out;
    for (int i = 0; i < 8; i++) drive(1'b1, 8'h60 + 8'(i), 1'b0, 8'h00, (i % 2) == 0);
    idle(10);
    check("toggle_count", n_out - base, 32'd8);

    // Lane 1 full, then push and pop on the same edges.
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1, 8'h20 + 8'(i), 1'b0);
    check("l1_full", {31'b0, full1}, 32'd1);
    for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b1, 8'h30 + 8'(i), 1'b1);
    idle(12);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
            $urandom_range(0, 3) != 0);
    idle(12);

    // Asynchronous reset mid-clock with 3 words buffered.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h40 + 8'(i), 1'b0, 8'h00, 1'b0);
    valid0 = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_valid_out", {31'b0, valid_out}, 32'd0);
    check("arst_data_out", {24'b0, data_out}, 32'd0);
    check("arst_full0", {31'b0, full0}, 32'd0);
    #10 rst = 1'b0;
    tick();
    idle(5);
    check("post_rst_idle", {31'b0, valid_out}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net: stop the run if it overruns its cycle budget.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
